// File: rtl/dmem_latency_responder.sv
// dmem_latency_responder: memory end of the hart's dmem port.
// It takes one word-aligned, byte-masked read or write request through a
// valid/ready handshake. It holds that request for LATENCY cycles and then
// returns a one-cycle response. The word array is synchronous and lives here.
// Only one request is outstanding at a time.
// Ports:
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_req_valid/ready   request handshake (ready is high only in IDLE)
//   i_req_addr          byte address, bits [1:0] ignored
//   i_req_ren/wen       read / write select (both set is an error)
//   i_req_wdata/mask    lane-placed write data and byte-lane enables
//   o_rsp_valid         one-cycle response pulse
//   o_rsp_rdata/err     lane-masked read data / illegal-request flag
module dmem_latency_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic [29:0] word_addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_c;
  req_t          req_q, req_in_c, req_cur_c;
  logic [30:0]   word_off_c;
  logic          below_base_c, beyond_c, req_err_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   mem [DEPTH_WORDS];

  // The byte-offset bits of the address carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_req_addr[1:0];

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign req_in_c = '{word_addr: i_req_addr[31:2], ren: i_req_ren, wen: i_req_wen,
                      wdata: i_req_wdata, mask: i_req_mask};

  // In IDLE the request being accepted is the live one, so LATENCY==1 can
  // resolve the array access on the accept edge itself.
  assign req_cur_c = (state_q == IDLE) ? req_in_c : req_q;

  // Word-granular offset with a borrow bit: the borrow flags addr < BASE_ADDR,
  // so out-of-range addresses never wrap into the array.
  assign word_off_c   = {1'b0, req_cur_c.word_addr} - {1'b0, BASE_ADDR[31:2]};
  assign below_base_c = word_off_c[30];
  assign beyond_c     = word_off_c[29:0] >= 30'(DEPTH_WORDS);
  assign idx_c        = word_off_c[AW-1:0];
  assign req_err_c    = (req_cur_c.ren & req_cur_c.wen) | (req_cur_c.mask == 4'b0000) |
                        below_base_c | beyond_c;

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid && (i_req_ren || i_req_wen)) begin
          accept_c = 1'b1;
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, handshake and response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_req_ready <= (state_d == IDLE);
      o_rsp_valid <= (state_d == RESP);
      if (state_d == RESP) begin
        o_rsp_err   <= req_err_c;
        o_rsp_rdata <= (req_cur_c.ren && !req_err_c) ? (mem[idx_c] & lane_mask(req_cur_c.mask))
                                                    : 32'h0;
      end
    end
  end

  // Request capture; the payload is sampled only on accept.
  always_ff @(posedge i_clk) begin
    if (accept_c) req_q <= req_in_c;
  end

  // Array write on the edge that ends RESP. A reset on that edge drops the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_q == RESP && req_q.wen && !req_err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.mask[b]) mem[idx_c][8*b +: 8] <= req_q.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_latency_responder.sv
// Testbench for dmem_latency_responder. A transaction-level model predicts
// ready, response timing, error and read data every cycle. Directed sequences
// pin the model with literal values, and randomized traffic follows.
module tb_dmem_latency_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ren = 1'b0;
  logic        i_req_wen = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_mask = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  dmem_latency_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_ren(i_req_ren), .i_req_wen(i_req_wen),
    .i_req_wdata(i_req_wdata), .i_req_mask(i_req_mask),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          live = 1'b0;
  int          next_free = 0;
  int          rsp_at = -1;
  bit          p_wen, exp_err;
  int          p_idx;
  logic [31:0] p_wdata, exp_rdata;
  logic [3:0]  p_mask;

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  always @(negedge i_clk) begin
    longint off;
    if (live) begin
      check("req_ready", 32'(o_req_ready), 32'(cyc >= next_free));
      check("rsp_valid", 32'(o_rsp_valid), 32'(cyc == rsp_at));
      if (cyc == rsp_at) begin
        check("rsp_err", 32'(o_rsp_err), 32'(exp_err));
        check("rsp_rdata", o_rsp_rdata, exp_rdata);
      end
    end
    if (i_rst) begin
      live      = 1'b1;
      rsp_at    = -1;
      next_free = cyc + 1;
    end else if (live) begin
      if (cyc == rsp_at) begin
        if (p_wen && !exp_err)
          for (int b = 0; b < 4; b++)
            if (p_mask[b]) m_mem[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
        rsp_at = -1;
      end
      if (cyc >= next_free && i_req_valid && (i_req_ren || i_req_wen)) begin
        off     = longint'({i_req_addr[31:2], 2'b00}) - longint'(BASE);
        exp_err = (i_req_ren && i_req_wen) || (i_req_mask == 4'b0000) ||
                  (off < 0) || ((off / 4) >= longint'(DEPTH));
        p_idx   = exp_err ? 0 : int'(off / 4);
        p_wen   = i_req_wen;
        p_wdata = i_req_wdata;
        p_mask  = i_req_mask;
        exp_rdata = (!exp_err && i_req_ren) ? (m_mem[p_idx] & lanes(i_req_mask)) : 32'h0;
        rsp_at    = cyc + int'(LAT);
        next_free = cyc + int'(LAT) + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic junk();
    i_req_valid = 1'($urandom);
    i_req_addr  = $urandom;
    i_req_ren   = 1'($urandom);
    i_req_wen   = 1'($urandom);
    i_req_wdata = $urandom;
    i_req_mask  = 4'($urandom);
  endtask

  // Issue one request and wait for its response.
  // Returns the response and the cycle count from accept to response.
  task automatic do_req(input logic [31:0] addr, input logic ren, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    i_req_valid = 1'b1; i_req_addr = addr; i_req_ren = ren; i_req_wen = wen;
    i_req_wdata = wdata; i_req_mask = mask;
    while (!o_req_ready && n < 50) begin @(posedge i_clk); #1; n++; end
    if (!o_req_ready) check("accept_timeout", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    lat = 1;
    junk();
    while (!o_rsp_valid && lat < 50) begin @(posedge i_clk); #1; lat++; junk(); end
    if (!o_rsp_valid) check("rsp_timeout", 32'(o_rsp_valid), 32'd1);
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    i_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, t0, t1, t2;
    logic [1:0]  rw;
    int          sel, w;
    logic [31:0] a;

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("reset_ready", 32'(o_req_ready), 32'd1);
    check("reset_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_rdata", o_rsp_rdata, 32'h0);
    check("reset_err", 32'(o_rsp_err), 32'd0);

    // Prefill every word the traffic below may read.
    for (int i = 0; i <= 16; i++) begin
      w = (i == 16) ? int'(DEPTH) - 1 : i;
      do_req(BASE + 32'(4 * w), 1'b0, 1'b1, 32'hC0DE_0000 | 32'(w), 4'hF, rd, er, lat);
    end

    // Full-word write, then read back.
    do_req(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("t1_lat", 32'(lat), 32'd2);
    check("t1_err", 32'(er), 32'd0);
    check("t1_rdata", rd, 32'h0);
    do_req(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("t2_lat", 32'(lat), 32'd2);
    check("t2_rdata", rd, 32'hDEAD_BEEF);

    // Single-byte write and masked reads.
    do_req(32'h12, 1'b0, 1'b1, 32'h00AB_0000, 4'b0100, rd, er, lat);
    do_req(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("t3_full", rd, 32'hDEAB_BEEF);
    do_req(32'h10, 1'b1, 1'b0, 32'h0, 4'b1100, rd, er, lat);
    check("t3_upper", rd, 32'hDEAB_0000);

    // Illegal requests.
    do_req(32'h10, 1'b1, 1'b1, 32'h1111_1111, 4'hF, rd, er, lat);
    check("t4_rw_err", 32'(er), 32'd1);
    check("t4_rw_rdata", rd, 32'h0);
    do_req(32'(4 * DEPTH), 1'b0, 1'b1, 32'h2222_2222, 4'hF, rd, er, lat);
    check("t4_range_err", 32'(er), 32'd1);
    do_req(32'h10, 1'b0, 1'b1, 32'h3333_3333, 4'h0, rd, er, lat);
    check("t4_mask_err", 32'(er), 32'd1);
    do_req(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("t4_unchanged", rd, 32'hDEAB_BEEF);

    // Reset while BUSY drops the write.
    i_req_valid = 1'b1; i_req_addr = 32'h20; i_req_ren = 1'b0; i_req_wen = 1'b1;
    i_req_wdata = 32'h1234_5678; i_req_mask = 4'hF;
    while (!o_req_ready) begin @(posedge i_clk); #1; end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("t5_ready", 32'(o_req_ready), 32'd1);
    check("t5_no_rsp", 32'(o_rsp_valid), 32'd0);
    do_req(32'h20, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("t5_rdata", rd, 32'hC0DE_0008);

    // Ignored request with neither read nor write.
    @(posedge i_clk); #1;
    i_req_valid = 1'b1; i_req_ren = 1'b0; i_req_wen = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
      check("t6_ignored", 32'(o_rsp_valid), 32'd0);
    end

    // Back-to-back reads with valid held high.
    do_req(32'h0, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    t0 = cyc;
    check("t6_rd0", rd, 32'hC0DE_0000);
    do_req(32'h4, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    t1 = cyc;
    check("t6_rd1", rd, 32'hC0DE_0001);
    do_req(32'h8, 1'b1, 1'b0, 32'h0, 4'hF, rd, er, lat);
    t2 = cyc;
    check("t6_rd2", rd, 32'hC0DE_0002);
    check("t6_gap01", 32'(t1 - t0), 32'd3);
    check("t6_gap12", 32'(t2 - t1), 32'd3);

    // Randomized traffic with idle gaps.
    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(0, 11));
      if (sel < 10) begin
        w = int'($urandom_range(0, 16));
        if (w == 16) w = int'(DEPTH) - 1;
        a = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      end else if (sel == 10) begin
        a = 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
      end else begin
        a = 32'hFFFF_FFFC;
      end
      rw = 2'($urandom_range(1, 3));
      do_req(a, rw[0], rw[1], $urandom, 4'($urandom), rd, er, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk); #1;
        i_req_valid = 1'($urandom); i_req_ren = 1'b0; i_req_wen = 1'b0;
        i_req_addr = $urandom;
      end
    end

    repeat (4) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
